// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit for the 16-bit core.
// Fetches over a req/ack handshake, decodes the 4-bit opcode and sequences
// FETCH/DECODE/EXEC/MEM/WB, driving ALU, regfile, data memory and PC control.
module mc_ctrl #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [3:0]         rf_raddr1,
    output logic [3:0]         rf_raddr2,
    output logic               rf_we,
    output logic [3:0]         rf_waddr,
    output logic               wb_sel,
    output logic [2:0]         alu_cmd,
    output logic               alu_src_imm,
    output logic [15:0]        imm,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ack,
    input  logic               br_zero,
    output logic               illegal,
    output logic [PC_W-1:0]    pc
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_SL   = 4'h6,
        OP_SR   = 4'h7,
        OP_SRU  = 4'h8,
        OP_ADDI = 4'h9,
        OP_LD   = 4'hA,
        OP_ST   = 4'hB,
        OP_BZ   = 4'hC
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SL  = 3'b101,
        ALU_SR  = 3'b110,
        ALU_SRU = 3'b111
    } alu_t;

    state_t             state;
    logic [INSTR_W-1:0] ir;
    logic [3:0]         op;
    alu_t               alu_next;
    logic               src_imm_next;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    br_off;
    logic [PC_W-1:0]    pc_br;

    assign op        = ir[15:12];
    assign imem_addr = pc;
    assign rf_raddr1 = ir[7:4];
    assign rf_raddr2 = (op == OP_ST || op == OP_BZ) ? ir[11:8] : ir[3:0];
    assign rf_waddr  = ir[11:8];

    // PC arithmetic wraps modulo 2^PC_W; the branch offset is sign-extended then truncated
    assign pc_inc = pc + PC_W'(1);
    assign br_off = PC_W'({{PC_W{ir[7]}}, ir[7:0]});
    assign pc_br  = pc_inc + br_off;

    // ALU function and operand-b select for the latched opcode
    always_comb begin
        alu_next     = ALU_ADD;
        src_imm_next = 1'b0;
        case (op)
            OP_SUB:                alu_next = ALU_SUB;
            OP_AND:                alu_next = ALU_AND;
            OP_OR:                 alu_next = ALU_OR;
            OP_XOR:                alu_next = ALU_XOR;
            OP_SL:                 alu_next = ALU_SL;
            OP_SR:                 alu_next = ALU_SR;
            OP_SRU:                alu_next = ALU_SRU;
            OP_ADDI, OP_LD, OP_ST: src_imm_next = 1'b1;
            default:               alu_next = ALU_ADD;
        endcase
    end

    // Sequencer: state, PC, IR and every strobe are registered together
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            pc          <= PC_W'(RESET_PC);
            ir          <= '0;
            imem_req    <= 1'b1;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            rf_we       <= 1'b0;
            wb_sel      <= 1'b0;
            illegal     <= 1'b0;
            alu_cmd     <= ALU_ADD;
            alu_src_imm <= 1'b0;
            imm         <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        illegal  <= (imem_rdata[15:12] > OP_BZ);
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    illegal     <= 1'b0;
                    alu_cmd     <= alu_next;
                    alu_src_imm <= src_imm_next;
                    imm         <= {{12{ir[3]}}, ir[3:0]};
                    state       <= S_EXEC;
                end
                S_EXEC: begin
                    case (op)
                        OP_LD, OP_ST: begin
                            dmem_req <= 1'b1;
                            dmem_we  <= (op == OP_ST);
                            state    <= S_MEM;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                        OP_SL, OP_SR, OP_SRU, OP_ADDI: begin
                            rf_we  <= 1'b1;
                            wb_sel <= 1'b0;
                            state  <= S_WB;
                        end
                        OP_BZ: begin
                            pc       <= br_zero ? pc_br : pc_inc;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        default: begin
                            pc       <= pc_inc;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (op == OP_ST) begin
                            pc       <= pc_inc;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end else begin
                            rf_we  <= 1'b1;
                            wb_sel <= 1'b1;
                            state  <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    rf_we    <= 1'b0;
                    wb_sel   <= 1'b0;
                    pc       <= pc_inc;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                default: begin
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
            endcase
        end
    end

endmodule
